// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between an AHB master/interconnect and the SRAM responder.
// hready is the interconnect-muxed ready, so it is driven from the master side.
interface ahb_sram_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [DATA_WIDTH-1:0] hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic [1:0]            hresp;
   logic [DATA_WIDTH-1:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: register-array memory, byte-lane writes,
// programmable wait states and two-cycle ERROR for illegal accesses.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no data phase pending, ready, OKAY
// ST_WAIT   | data phase stalled, wait_cnt counts down to 0
// ST_ACCESS | data phase completes this cycle (write commits at closing edge)
// ST_ERR1   | first ERROR cycle, hreadyout low
// ST_ERR2   | second ERROR cycle, hreadyout high, may accept next address
module ahb_sram_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic             hclk,
   input  logic             hresetn,
   ahb_sram_slave_if.slave  bus
);

   localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [14:0] DEPTH_LIM = 15'(MEM_DEPTH);
   localparam logic [1:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_ACCESS = 3'd2,
      ST_ERR1   = 3'd3,
      ST_ERR2   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       wait_cnt;
   logic [IDX_W-1:0] dp_index;
   logic [3:0]       dp_mask;
   logic             dp_write;

   logic             ph_open;
   logic             accept;
   logic             addr_err;
   logic [13:0]      a_index;
   logic [3:0]       a_mask;

   logic [31:0]      mem [MEM_DEPTH];

   logic             unused_bits;
   assign unused_bits = ^{bus.haddr[ADDR_WIDTH-1:16], bus.hburst, bus.htrans[0], a_index};

   assign a_index = bus.haddr[15:2];
   assign ph_open = (state == ST_IDLE) || (state == ST_ACCESS) || (state == ST_ERR2);
   assign accept  = bus.hsel & bus.hready & bus.htrans[1] & ph_open;

   // Lane mask and legality of the address phase currently on the bus.
   always_comb begin
      a_mask   = 4'b0000;
      addr_err = 1'b0;
      case (bus.hsize)
         3'd0: a_mask = 4'b0001 << bus.haddr[1:0];
         3'd1: begin
            a_mask   = bus.haddr[1] ? 4'b1100 : 4'b0011;
            addr_err = bus.haddr[0];
         end
         3'd2: begin
            a_mask   = 4'b1111;
            addr_err = |bus.haddr[1:0];
         end
         default: addr_err = 1'b1;
      endcase
      if ({1'b0, a_index} >= DEPTH_LIM) begin
         addr_err = 1'b1;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_ACCESS, ST_ERR2: begin
            if (!accept) begin
               state_nxt = ST_IDLE;
            end else if (addr_err) begin
               state_nxt = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
               state_nxt = ST_WAIT;
            end else begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 2'd0) begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.hreadyout = 1'b1;
      bus.hresp     = 2'b00;
      bus.hrdata    = '0;
      case (state)
         ST_WAIT: bus.hreadyout = 1'b0;
         ST_ERR1: begin
            bus.hreadyout = 1'b0;
            bus.hresp     = 2'b01;
         end
         ST_ERR2: bus.hresp = 2'b01;
         ST_ACCESS: begin
            if (!dp_write) begin
               bus.hrdata = mem[dp_index];
            end
         end
         default: ;
      endcase
   end

   // Data-phase registers and the wait-state down-counter.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         wait_cnt <= 2'd0;
         dp_index <= '0;
         dp_mask  <= 4'b0000;
         dp_write <= 1'b0;
      end else begin
         if (accept) begin
            dp_index <= a_index[IDX_W-1:0];
            dp_mask  <= a_mask;
            dp_write <= bus.hwrite;
         end
         if (accept && !addr_err) begin
            wait_cnt <= WAIT_LOAD;
         end else if ((state == ST_WAIT) && (wait_cnt != 2'd0)) begin
            wait_cnt <= wait_cnt - 2'd1;
         end
      end
   end

   // Storage is deliberately not reset; only ACCESS of a write touches it.
   always_ff @(posedge hclk) begin
      if ((state == ST_ACCESS) && dp_write) begin
         for (int b = 0; b < 4; b++) begin
            if (dp_mask[b]) begin
               mem[dp_index][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one instance with zero and one with two wait states.
module tb_ahb_sram_slave;

   typedef struct {
      bit          rd;
      logic [31:0] data;
      bit          err;
      int          waits;
   } exp_t;

   logic hclk;
   logic hresetn;

   logic        m_hsel   [2];
   logic [31:0] m_haddr  [2];
   logic [1:0]  m_htrans [2];
   logic        m_hwrite [2];
   logic [2:0]  m_hsize  [2];
   logic [2:0]  m_hburst [2];
   logic [31:0] m_hwdata [2];

   exp_t q0[$];
   exp_t q1[$];

   int   checks;
   int   errors;
   bit   in_dp [2];
   int   wcnt  [2];
   logic [1:0] wresp [2];

   ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

   assign bus0.hsel   = m_hsel[0];
   assign bus0.haddr  = m_haddr[0];
   assign bus0.htrans = m_htrans[0];
   assign bus0.hwrite = m_hwrite[0];
   assign bus0.hsize  = m_hsize[0];
   assign bus0.hburst = m_hburst[0];
   assign bus0.hwdata = m_hwdata[0];
   assign bus0.hready = bus0.hreadyout;

   assign bus2.hsel   = m_hsel[1];
   assign bus2.haddr  = m_haddr[1];
   assign bus2.htrans = m_htrans[1];
   assign bus2.hwrite = m_hwrite[1];
   assign bus2.hsize  = m_hsize[1];
   assign bus2.hburst = m_hburst[1];
   assign bus2.hwdata = m_hwdata[1];
   assign bus2.hready = bus2.hreadyout;

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus0)
   );

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(2)) u_dut2 (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus2)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   function automatic int ws(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic logic rdy(input int d);
      return (d == 0) ? bus0.hreadyout : bus2.hreadyout;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h exp 0x%08h", nm, got, exp);
      end
   endtask

   // Data-phase monitor: tracks accepted address phases and scores each completion.
   task automatic mon(input int d, input logic sel, input logic [1:0] tr, input logic rd_y,
                      input logic [1:0] resp, input logic [31:0] rdat);
      exp_t e;
      bit   have;
      if (!hresetn) begin
         in_dp[d] = 1'b0;
         return;
      end
      if (in_dp[d]) begin
         if (!rd_y) begin
            wcnt[d]++;
            wresp[d] = resp;
         end else begin
            have = 1'b0;
            if (d == 0) begin
               if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            end else begin
               if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            end
            if (!have) begin
               checks++;
               errors++;
               $display("FAIL unexpected_dp dut=%0d got completion exp none", d);
            end else begin
               chk($sformatf("waits dut=%0d", d), 32'(wcnt[d]), 32'(e.waits));
               chk($sformatf("resp dut=%0d", d), {30'd0, resp}, e.err ? 32'd1 : 32'd0);
               if (e.waits > 0) begin
                  chk($sformatf("wait_resp dut=%0d", d), {30'd0, wresp[d]}, e.err ? 32'd1 : 32'd0);
               end
               chk($sformatf("rdata dut=%0d", d), rdat, (e.rd && !e.err) ? e.data : 32'd0);
            end
            in_dp[d] = 1'b0;
         end
      end
      if (sel && rd_y && tr[1]) begin
         in_dp[d] = 1'b1;
         wcnt[d]  = 0;
         wresp[d] = 2'b00;
      end
   endtask

   always @(negedge hclk) begin
      mon(0, bus0.hsel, bus0.htrans, bus0.hreadyout, bus0.hresp, bus0.hrdata);
      mon(1, bus2.hsel, bus2.htrans, bus2.hreadyout, bus2.hresp, bus2.hrdata);
   end

   task automatic wait_ready(input int d, input string nm);
      int n;
      n = 0;
      @(negedge hclk);
      while (!rdy(d) && n < 20) begin
         @(negedge hclk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL timeout %s dut=%0d got hreadyout=0 exp 1", nm, d);
      end
      @(posedge hclk);
      #2;
   endtask

   task automatic beat(input int d, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] bu,
                       input bit e_err, input logic [31:0] e_rd);
      exp_t e;
      m_hsel[d]   = 1'b1;
      m_htrans[d] = tr;
      m_hwrite[d] = wr;
      m_hsize[d]  = sz;
      m_haddr[d]  = a;
      m_hburst[d] = bu;
      e.rd    = !wr;
      e.data  = e_rd;
      e.err   = e_err;
      e.waits = e_err ? 1 : ws(d);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      wait_ready(d, "accept");
      if (wr) m_hwdata[d] = wd;
   endtask

   task automatic wrw(input int d, input logic [31:0] a, input logic [31:0] wd);
      beat(d, 2'b10, 1'b1, 3'd2, a, wd, 3'd0, 1'b0, 32'd0);
   endtask

   task automatic rdw(input int d, input logic [31:0] a, input logic [31:0] ex);
      beat(d, 2'b10, 1'b0, 3'd2, a, 32'd0, 3'd0, 1'b0, ex);
   endtask

   task automatic errb(input int d, input logic wr, input logic [2:0] sz, input logic [31:0] a);
      beat(d, 2'b10, wr, sz, a, 32'hFFFF_FFFF, 3'd0, 1'b1, 32'd0);
   endtask

   task automatic idle(input int d);
      m_hsel[d]   = 1'b0;
      m_htrans[d] = 2'b00;
      wait_ready(d, "idle");
      @(posedge hclk);
      #2;
   endtask

   task automatic chk_rst_outputs(input string tag);
      chk({tag, " rdy0"},  {31'd0, bus0.hreadyout}, 32'd1);
      chk({tag, " resp0"}, {30'd0, bus0.hresp},     32'd0);
      chk({tag, " rd0"},   bus0.hrdata,             32'd0);
      chk({tag, " rdy2"},  {31'd0, bus2.hreadyout}, 32'd1);
      chk({tag, " resp2"}, {30'd0, bus2.hresp},     32'd0);
      chk({tag, " rd2"},   bus2.hrdata,             32'd0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      for (int d = 0; d < 2; d++) begin
         m_hsel[d]   = 1'b0;
         m_haddr[d]  = 32'd0;
         m_htrans[d] = 2'b00;
         m_hwrite[d] = 1'b0;
         m_hsize[d]  = 3'd0;
         m_hburst[d] = 3'd0;
         m_hwdata[d] = 32'd0;
         in_dp[d]    = 1'b0;
         wcnt[d]     = 0;
         wresp[d]    = 2'b00;
      end
      hresetn = 1'b1;
      #1 hresetn = 1'b0;
      #2 chk_rst_outputs("rst_init");
      #9 hresetn = 1'b1;
      @(posedge hclk);
      #2;

      // Zero-wait instance: word write then read.
      wrw(0, 32'h4000_0010, 32'h0000_000B);
      rdw(0, 32'h4000_0010, 32'h0000_000B);

      // Byte lanes: junk on unselected lanes must be ignored.
      wrw(0, 32'h4000_0068, 32'hFFFF_FFFF);
      beat(0, 2'b10, 1'b1, 3'd0, 32'h4000_0069, 32'h7766_5A44, 3'd0, 1'b0, 32'd0);
      beat(0, 2'b10, 1'b1, 3'd1, 32'h4000_006A, 32'h1234_9988, 3'd0, 1'b0, 32'd0);
      rdw(0, 32'h4000_0068, 32'h1234_5AFF);

      // Errors leave memory untouched, including the aliased index 0.
      wrw(0, 32'h4000_001C, 32'hCAFE_F00D);
      wrw(0, 32'h4000_0020, 32'h0102_0304);
      wrw(0, 32'h4000_0000, 32'h0BAD_BEEF);
      errb(0, 1'b1, 3'd2, 32'h4000_001E);
      errb(0, 1'b1, 3'd3, 32'h4000_0020);
      errb(0, 1'b1, 3'd2, 32'h4000_0100);
      errb(0, 1'b0, 3'd1, 32'h4000_0011);
      rdw(0, 32'h4000_001C, 32'hCAFE_F00D);
      rdw(0, 32'h4000_0020, 32'h0102_0304);
      rdw(0, 32'h4000_0000, 32'h0BAD_BEEF);

      // Last valid word, then a byte into its top lane.
      wrw(0, 32'h4000_00FC, 32'h89AB_CDEF);
      rdw(0, 32'h4000_00FC, 32'h89AB_CDEF);
      beat(0, 2'b10, 1'b1, 3'd0, 32'h4000_00FF, 32'h5500_0000, 3'd0, 1'b0, 32'd0);
      rdw(0, 32'h4000_00FC, 32'h55AB_CDEF);

      // Back-to-back read/write/read of the same word.
      wrw(0, 32'h4000_0024, 32'h1111_2222);
      rdw(0, 32'h4000_0024, 32'h1111_2222);
      wrw(0, 32'h4000_0024, 32'h3333_4444);
      rdw(0, 32'h4000_0024, 32'h3333_4444);
      idle(0);

      // Two-wait instance: INCR4 write and read bursts.
      beat(1, 2'b10, 1'b1, 3'd2, 32'h4000_0090, 32'd50, 3'b011, 1'b0, 32'd0);
      beat(1, 2'b11, 1'b1, 3'd2, 32'h4000_0094, 32'd51, 3'b011, 1'b0, 32'd0);
      beat(1, 2'b11, 1'b1, 3'd2, 32'h4000_0098, 32'd53, 3'b011, 1'b0, 32'd0);
      beat(1, 2'b11, 1'b1, 3'd2, 32'h4000_009C, 32'd58, 3'b011, 1'b0, 32'd0);
      beat(1, 2'b10, 1'b0, 3'd2, 32'h4000_0090, 32'd0, 3'b011, 1'b0, 32'd50);
      beat(1, 2'b11, 1'b0, 3'd2, 32'h4000_0094, 32'd0, 3'b011, 1'b0, 32'd51);
      beat(1, 2'b11, 1'b0, 3'd2, 32'h4000_0098, 32'd0, 3'b011, 1'b0, 32'd53);
      beat(1, 2'b11, 1'b0, 3'd2, 32'h4000_009C, 32'd0, 3'b011, 1'b0, 32'd58);

      // ERROR stays two cycles even with wait states configured.
      errb(1, 1'b0, 3'd3, 32'h4000_0090);
      rdw(1, 32'h4000_0090, 32'd50);

      // Async reset during WAIT drops the in-flight write.
      wrw(1, 32'h4000_0050, 32'hAAAA_5555);
      rdw(1, 32'h4000_0050, 32'hAAAA_5555);
      idle(1);
      wrw(1, 32'h4000_0050, 32'h1111_1111);
      m_hsel[1]   = 1'b0;
      m_htrans[1] = 2'b00;
      #1 hresetn = 1'b0;
      #1 chk_rst_outputs("rst_mid");
      q1.delete();
      #10 hresetn = 1'b1;
      @(posedge hclk);
      #2;
      rdw(1, 32'h4000_0050, 32'hAAAA_5555);
      idle(1);

      repeat (3) @(posedge hclk);
      #2;
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder with a register-array memory and programmable wait states: the slave end of the AHB master/interconnect path in the multi-slave bus. It decodes single and burst transfers of byte, halfword and word size. It performs little-endian byte-lane writes and returns read data. Misaligned, oversize and out-of-range accesses get the two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (fixed at 32 for this block)
- MEM_DEPTH, 64, number of 32-bit words, 1..16384
- WAIT_STATES, 0, wait cycles inserted per data phase, 0..3
- hclk  in  1  bus clock, all logic on rising edge
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select from decoder
- haddr  in  ADDR_WIDTH  address-phase address
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  in  1  1 = write
- hsize  in  3  0 byte, 1 half, 2 word, others illegal
- hburst  in  3  burst type, accepted but not used for addressing
- hwdata  in  DATA_WIDTH  write data, valid in data phase
- hready  in  1  bus-level ready (muxed hreadyout)
- hreadyout  out  1  slave ready
- hresp  out  2  00 OKAY, 01 ERROR
- hrdata  out  DATA_WIDTH  read data

## Operation
- Address phase accepted when hsel & hready & htrans[1] at a rising edge. The slave latches addr, write, size and an error flag into data-phase registers. IDLE and BUSY, or no hsel, are not accepted and give an OKAY zero-wait response.
- Word index = haddr[15:2].
- Error flag is set if any of these hold:
  - hsize > 2
  - hsize = 1 and haddr[0] = 1
  - hsize = 2 and haddr[1:0] ≠ 0
  - index ≥ MEM_DEPTH
- FSM states: IDLE, WAIT, ACCESS, ERR1, ERR2.
- IDLE: hreadyout=1, hresp=00. On accept:
  - error flag set → ERR1
  - WAIT_STATES > 0 → WAIT, with the counter loaded to WAIT_STATES-1
  - otherwise → ACCESS
- WAIT: hreadyout=0, hresp=00. Counter decrements each cycle. When the counter is 0, go to ACCESS.
- ACCESS: hreadyout=1, hresp=00, and the data phase completes this cycle.
  - Write: at the closing edge, the byte lanes selected by size and addr[1:0] are updated from hwdata; other lanes are unchanged. Byte n = hwdata[8n+7:8n].
  - Read: hrdata = mem[index] as a full word. All lanes are driven and the master selects.
  - Next state follows the IDLE accept rules, so back-to-back transfers pipeline.
- ERR1: hreadyout=0, hresp=01. Memory is not touched. Always goes to ERR2.
- ERR2: hreadyout=1, hresp=01. The next state follows the IDLE accept rules.
- hrdata = 0 except in ACCESS of a read.
- Read-after-write to the same word returns the new data. The write commits at the edge ending its ACCESS, and the read data phase starts at or after that edge.
- Bursts: each beat uses the haddr the master presents. The slave computes no addresses, so it does not check for a wrap or 1KB boundary.
- Memory array is not reset. Contents are undefined until written.

## Timing
- Reset (async, hresetn=0): state=IDLE, hreadyout=1, hresp=00, hrdata=0, counter=0. Any in-flight write is dropped.
- Deasserting hresetn mid-burst: the slave restarts in IDLE and ignores the remaining beats until a new accepted address phase.
- Write latency: address-phase edge plus (WAIT_STATES+1) cycles to commit.
- Read data: valid in the cycle hreadyout=1, WAIT_STATES cycles after the address-phase edge.
- Pipelining: while in WAIT, hready=0, so no new address phase is accepted. The address phase presented during ACCESS or ERR2 is accepted at the same edge that completes the current data phase.
- ERROR is always exactly 2 cycles, with hresp=01 in both cycles.
- htrans=IDLE presented during ERR1 is legal, and then ERR2 → IDLE.

## Test plan
- Reset: hresetn=0 mid-run → hreadyout=1, hresp=00, hrdata=0 asynchronously. No write commits.
- Word write, WAIT_STATES=0:
  - Stimulus: NONSEQ write, haddr=0x40000010, hsize=2, hwdata=0x0000000B, then NONSEQ read of the same address.
  - Required: hrdata=0x0000000B in the read's data phase. Zero waits.
- INCR4 write burst at 0x40000090 with data 50, 51, 53, 58, WAIT_STATES=2, then an INCR4 read:
  - Every beat shows 2 cycles with hreadyout=0.
  - Reads return 50, 51, 53, 58.
- Byte lanes:
  - Preset the word at 0x40000068 to 0xFFFFFFFF.
  - Byte write 0x5A to 0x40000069, then halfword write 0x1234 to 0x4000006A.
  - Read returns 0x12345AFF.
- Errors, each of which gives hreadyout 0 then 1 with hresp=01 for both cycles and leaves memory unchanged:
  - Word access at 0x4000001E
  - Index ≥ MEM_DEPTH (0x40000100 with depth 64)
  - hsize=3
- Back-to-back accesses: read of A in ACCESS while a write address phase to A is accepted.
  - The write commits next. A following read of A returns the new value.
  - No stall is added beyond WAIT_STATES.
